// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, single-outstanding word reads, instruction FIFO to decode
// Optional IFU_BYPASS_EN: empty-FIFO read data is forwarded to ir in the cycle it returns.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FULL, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [DATA_W-1:0] buf_data_d [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_d [DEPTH];

  logic rsp_take;
  logic bypass;
  logic push;
  logic pop;

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = fetch_pc_q;

  always_comb begin
    rsp_take = (state_q == S_WAIT) && mem_rvalid && !redirect;
`ifdef IFU_BYPASS_EN
    bypass = rsp_take && (count_q == '0);
`else
    bypass = 1'b0;
`endif
    ir_valid = (count_q != '0) || bypass;
    ir       = bypass ? mem_rdata : buf_data_q[rd_ptr_q];
    ir_pc    = bypass ? fetch_pc_q : buf_pc_q[rd_ptr_q];
    pop      = (count_q != '0) && ir_ready && !redirect;
    // A bypassed word taken by decode never occupies a FIFO slot
    push     = rsp_take && !(bypass && ir_ready);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;

    if (push) begin
      buf_data_d[wr_ptr_q] = mem_rdata;
      buf_pc_d[wr_ptr_q]   = fetch_pc_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (rsp_take) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (mem_gnt) state_d = S_WAIT;
      S_WAIT: if (mem_rvalid) state_d = (count_d < FULL_CNT) ? S_REQ : S_FULL;
      S_FULL: if (count_d < FULL_CNT) state_d = S_REQ;
      S_DROP: if (mem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    // Redirect wins; a request already granted still owes one response
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      unique case (state_q)
        S_REQ:          state_d = mem_gnt ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = mem_rvalid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_pc_q[i]   <= buf_pc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a memory and stream model
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic [31:0] ir_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instructions reach decode in address order from the last redirect target
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_fetch;
  bit          out_busy, out_live;
  int          out_wait;
  logic [31:0] out_addr;
  bit          idle_cyc, stale_pending;

  int gnt_pct, lat_min, lat_max, ready_pct, redir_pct;
  int force_ready = -1;
  bit force_redir = 0;
  logic [31:0] force_pc;

  bit obs_req, obs_valid, popped;
  logic [31:0] obs_addr, popped_pc;
  int n_grant, n_pop;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(3))
      0: return 32'hFFFF_FFFE;
      1: return $urandom_range(255);
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    bit rsp, live_rsp, exp_req, exp_valid, byp, grant, pop;
    ent_t e;
    @(negedge clk);
    rsp = 0;
    if (stale_pending) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; stale_pending = 0;
    end else if (out_busy && out_wait == 0) begin
      rsp = 1; mem_rvalid = 1'b1; mem_rdata = memf(out_addr);
    end else begin
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    mem_gnt = ($urandom_range(99) < gnt_pct);
    if (force_ready >= 0) ir_ready = (force_ready != 0);
    else ir_ready = ($urandom_range(99) < ready_pct);
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 0;
    end else begin
      redirect = ($urandom_range(99) < redir_pct); redirect_pc = pick_pc();
    end
    #1;
    live_rsp = rsp && out_live;
    exp_req  = !idle_cyc && !out_busy && (q.size() < DEPTH);
    byp = 0;
`ifdef IFU_BYPASS_EN
    byp = live_rsp && !redirect && (q.size() == 0);
`endif
    exp_valid = (q.size() != 0) || byp;
    check("mem_req", mem_req, exp_req);
    if (exp_req) check("mem_addr", mem_addr, exp_fetch);
    check("ir_valid", ir_valid, exp_valid);
    if (byp) begin
      check("ir_byp", ir, memf(out_addr));
      check("ir_pc_byp", ir_pc, out_addr);
    end else if (q.size() != 0) begin
      check("ir", ir, q[0].data);
      check("ir_pc", ir_pc, q[0].pc);
    end
    obs_req = mem_req; obs_addr = mem_addr; obs_valid = ir_valid;

    grant  = exp_req && mem_gnt;
    pop    = exp_valid && ir_ready && !redirect;
    popped = pop;
    popped_pc = byp ? out_addr : ((q.size() != 0) ? q[0].pc : 32'h0);
    if (grant) n_grant++;
    if (pop) n_pop++;

    if (out_busy && !rsp && out_wait > 0) out_wait--;
    if (rsp) out_busy = 0;
    if (redirect) begin
      q.delete();
      if (grant) begin
        out_busy = 1; out_addr = exp_fetch; out_wait = $urandom_range(lat_max, lat_min) - 1;
      end
      out_live  = 0;
      exp_fetch = redirect_pc;
    end else begin
      if (pop && !byp) void'(q.pop_front());
      if (live_rsp && !(byp && ir_ready)) begin
        e.data = memf(out_addr); e.pc = out_addr;
        q.push_back(e);
      end
      if (grant) begin
        out_busy = 1; out_live = 1; out_addr = exp_fetch;
        out_wait = $urandom_range(lat_max, lat_min) - 1;
        exp_fetch = exp_fetch + 32'd1;
      end
    end
    idle_cyc = 0;
    @(posedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_gnt = 0; mem_rvalid = 0; redirect = 0; ir_ready = 0;
    mem_rdata = '0; redirect_pc = '0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, RESET_PC);
    check("rst_valid", ir_valid, 0);
    check("rst_ir", ir, 0);
    check("rst_ir_pc", ir_pc, 0);
    stale_pending = out_busy;
    q.delete(); out_busy = 0; out_live = 0; exp_fetch = RESET_PC;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    idle_cyc = 1;
  endtask

  initial begin
    int k;
    gnt_pct = 100; lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;
    out_busy = 0; out_live = 0; out_wait = 0; out_addr = '0; stale_pending = 0;
    exp_fetch = RESET_PC; idle_cyc = 1; n_grant = 0; n_pop = 0;

    // back-to-back fetch, one instruction every two cycles
    do_reset();
    step();
    check("t1_idle_req", obs_req, 0);
    step();
    check("t1_first_addr", obs_addr, RESET_PC);
    run(10);
    n_pop = 0;
    run(40);
    check("t1_rate", n_pop, 20);

    // stalled decode fills the FIFO, one pop resumes fetching
    ready_pct = 0; n_grant = 0;
    do_reset();
    run(20);
    check("t2_fetches", n_grant, DEPTH);
    check("t2_req_off", obs_req, 0);
    force_ready = 1; step(); force_ready = -1;
    step();
    check("t2_req_on", obs_req, 1);
    check("t2_addr", obs_addr, 32'd4);

    // redirect while a response is outstanding
    ready_pct = 100; lat_min = 3; lat_max = 3;
    k = 0;
    while (!(out_busy && out_live && out_wait > 0) && k < 50) begin step(); k++; end
    check("t3_setup", k < 50, 1);
    force_redir = 1; force_pc = 32'h100; step();
    k = 0;
    do begin step(); k++; end while (!popped && k < 50);
    check("t3_first_pc", popped_pc, 32'h100);

    // redirect coinciding with a returning word and a pop
    ready_pct = 0; lat_min = 1; lat_max = 1;
    k = 0;
    while (!(q.size() >= 1 && out_busy && out_live && out_wait == 0) && k < 50) begin step(); k++; end
    check("t4_setup", k < 50, 1);
    force_redir = 1; force_pc = 32'h2000; force_ready = 1; step(); force_ready = -1;
    step();
    check("t4_empty", obs_valid, 0);
    check("t4_req", obs_req, 1);
    check("t4_addr", obs_addr, 32'h2000);

    // fetch PC wraps at the top of the address space
    ready_pct = 100;
    force_redir = 1; force_pc = 32'hFFFF_FFFF; step();
    k = 0;
    do begin step(); k++; end while (!(obs_req && obs_addr != 32'hFFFF_FFFF) && k < 20);
    check("t5_wrap", obs_addr, 32'h0);

    // reset in WAIT with three buffered words
    ready_pct = 0; lat_min = 3; lat_max = 3;
    k = 0;
    while (!(q.size() == 3 && out_busy) && k < 60) begin step(); k++; end
    check("t6_setup", k < 60, 1);
    do_reset();
    ready_pct = 100; lat_min = 1; lat_max = 1;
    step();
    check("t6_idle", obs_req, 0);
    step();
    check("t6_restart", obs_addr, RESET_PC);
    run(30);

    // random traffic with redirects
    gnt_pct = 60; lat_min = 1; lat_max = 4; ready_pct = 50; redir_pct = 3;
    run(3000);
    do_reset();
    gnt_pct = 80; ready_pct = 90; redir_pct = 1;
    run(1000);
    gnt_pct = 100; lat_max = 2; ready_pct = 20; redir_pct = 2;
    run(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
